// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB loopback subsystem.
//   apb_state_t  master FSM states (IDLE, SETUP, ACCESS)
//   CMD_*        encodings of the 2-bit add_i command
//   APB_AW/DW    address / data bus widths
package apb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b11;

    // 2'b10 is reserved and deliberately treated the same as idle.
    function automatic logic cmd_is_xfer(input logic [1:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

endpackage

// File: rtl/apb_interface.sv
// apb_interface: APB signal bundle between the command master and the
// register-file slave.
//   pclk, preset_n   clock and asynchronous active-high reset
//   psel, penable, pwrite, paddr, pwdata   driven by the master
//   prdata, pready, pslverr                driven by the slave
interface apb_interface
    import apb_pkg::*;
(
    input logic pclk,
    input logic preset_n
);

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [APB_AW-1:0] paddr;
    logic [APB_DW-1:0] pwdata;
    logic [APB_DW-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  pclk, preset_n, prdata, pready, pslverr,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        input  pclk, preset_n, psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns the 2-bit command into single APB transfers to one
// fixed address, and reports completion / read data.
//   bus               APB master modport (clock and reset come from here)
//   add_i             command: 00 idle, 01 read, 11 write, 10 reserved
//   external_wdata_i  write data, captured on entry to SETUP
//   ready_o           high in the cycle a transfer completes
//   rdata_o           last completed read data, held between reads
//
// state  | meaning
// IDLE   | bus quiet, waiting for a read/write command
// SETUP  | psel=1, penable=0, address/direction/data presented
// ACCESS | psel=1, penable=1, waiting for pready
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter logic [APB_AW-1:0] TXN_ADDR = 32'h0000_0010
) (
    apb_interface.master        bus,
    input  logic [1:0]          add_i,
    input  logic [APB_DW-1:0]   external_wdata_i,
    output logic                ready_o,
    output logic [APB_DW-1:0]   rdata_o
);

    apb_state_t state;
    logic       xfer_done;

    assign xfer_done = bus.psel & bus.penable & bus.pready;
    assign ready_o   = xfer_done;

    always_ff @(posedge bus.pclk or posedge bus.preset_n) begin
        if (bus.preset_n) begin
            state       <= IDLE;
            bus.psel    <= 1'b0;
            bus.penable <= 1'b0;
            bus.pwrite  <= 1'b0;
            bus.paddr   <= '0;
            bus.pwdata  <= '0;
            rdata_o     <= '0;
        end else begin
            if (xfer_done && !bus.pwrite && !bus.pslverr) begin
                rdata_o <= bus.prdata;
            end

            case (state)
                IDLE: begin
                    bus.penable <= 1'b0;
                    if (cmd_is_xfer(add_i)) begin
                        state      <= SETUP;
                        bus.psel   <= 1'b1;
                        bus.paddr  <= TXN_ADDR;
                        bus.pwrite <= add_i[1];
                        bus.pwdata <= external_wdata_i;
                    end else begin
                        bus.psel <= 1'b0;
                    end
                end

                SETUP: begin
                    state       <= ACCESS;
                    bus.penable <= 1'b1;
                end

                ACCESS: begin
                    if (bus.pready) begin
                        bus.penable <= 1'b0;
                        if (cmd_is_xfer(add_i)) begin
                            // back-to-back: psel stays high, go straight to SETUP
                            state      <= SETUP;
                            bus.pwrite <= add_i[1];
                            bus.pwdata <= external_wdata_i;
                        end else begin
                            state    <= IDLE;
                            bus.psel <= 1'b0;
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    bus.psel    <= 1'b0;
                    bus.penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB register file with a programmable number of wait states.
//   bus          APB slave modport (clock and reset come from here)
//   MEM_DEPTH    number of 32-bit registers, word index = paddr[IDX_W+1:2]
//   WAIT_STATES  cycles pready is withheld in ACCESS (0..7)
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 0
) (
    apb_interface.slave bus
);

    localparam int         IDX_W   = $clog2(MEM_DEPTH);
    localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES);

    logic [APB_DW-1:0] mem [MEM_DEPTH];
    logic [2:0]        wait_cnt;
    logic [IDX_W-1:0]  idx;
    logic              access;
    logic              unused_addr_bits;

    assign idx    = bus.paddr[IDX_W+1:2];
    assign access = bus.psel & bus.penable;

    // Down-counter is reloaded whenever the bus is not in a waiting ACCESS,
    // so it already holds WAIT_STATES on the first ACCESS cycle.
    assign bus.pready  = access & (wait_cnt == 3'd0);
    assign bus.pslverr = 1'b0;
    assign bus.prdata  = (bus.psel & ~bus.pwrite) ? mem[idx] : '0;

    assign unused_addr_bits = ^{bus.paddr[APB_AW-1:IDX_W+2], bus.paddr[1:0]};

    always_ff @(posedge bus.pclk or posedge bus.preset_n) begin
        if (bus.preset_n) begin
            wait_cnt <= 3'd0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (!access || bus.pready) begin
                wait_cnt <= WS_LOAD;
            end else begin
                wait_cnt <= wait_cnt - 3'd1;
            end

            if (bus.pready && bus.pwrite) begin
                mem[idx] <= bus.pwdata;
            end
        end
    end

endmodule

// File: rtl/apb_master_slave_sys.sv
// apb_master_slave_sys: bring-up/loopback APB subsystem. A command-driven
// master performs single reads/writes of one fixed slave word.
//   pclk              clock
//   preset_n          asynchronous reset, active high
//   add_i             command: 00 idle, 01 read, 11 write, 10 reserved (idle)
//   external_wdata_i  write data
//   ready_o           one-cycle pulse when a transfer completes
//   rdata_o           last read result, held until the next read completes
module apb_master_slave_sys
    import apb_pkg::*;
#(
    parameter logic [APB_AW-1:0] TXN_ADDR    = 32'h0000_0010,
    parameter int                MEM_DEPTH   = 16,
    parameter int                WAIT_STATES = 0
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic [1:0]        add_i,
    input  logic [APB_DW-1:0] external_wdata_i,
    output logic              ready_o,
    output logic [APB_DW-1:0] rdata_o
);

    apb_interface apb_if (
        .pclk     (pclk),
        .preset_n (preset_n)
    );

    apb_cmd_master #(
        .TXN_ADDR (TXN_ADDR)
    ) u_master (
        .bus              (apb_if.master),
        .add_i            (add_i),
        .external_wdata_i (external_wdata_i),
        .ready_o          (ready_o),
        .rdata_o          (rdata_o)
    );

    apb_reg_slave #(
        .MEM_DEPTH   (MEM_DEPTH),
        .WAIT_STATES (WAIT_STATES)
    ) u_slave (
        .bus (apb_if.slave)
    );

endmodule

// File: tb/tb_apb_master_slave_sys.sv
module tb_apb_master_slave_sys;
    import apb_pkg::*;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic [1:0]  add_i, add2;
    logic [31:0] wdata, wdata2;
    logic        ready_o, ready2;
    logic [31:0] rdata_o, rdata2;

    always #5 pclk = ~pclk;

    apb_master_slave_sys #(.WAIT_STATES(0)) dut0 (
        .pclk (pclk), .preset_n (preset_n), .add_i (add_i),
        .external_wdata_i (wdata), .ready_o (ready_o), .rdata_o (rdata_o)
    );

    apb_master_slave_sys #(.WAIT_STATES(2)) dut2 (
        .pclk (pclk), .preset_n (preset_n), .add_i (add2),
        .external_wdata_i (wdata2), .ready_o (ready2), .rdata_o (rdata2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // scoreboard for dut0: one record per issued transfer
    typedef struct packed {
        logic        is_read;
        logic [31:0] exp;
    } sb_t;
    sb_t         sb_q[$];
    sb_t         mon_e;
    logic [31:0] model_word;
    logic [31:0] last_rd;

    always @(negedge pclk) begin
        if (!preset_n && ready_o) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                @(posedge pclk);
                #1;
                if (mon_e.is_read) begin
                    chk("sb_read_data", rdata_o, mon_e.exp);
                    last_rd = mon_e.exp;
                end else begin
                    chk("sb_write_keeps_rdata", rdata_o, last_rd);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] cmd, input logic [31:0] wd);
        add_i = cmd;
        wdata = wd;
        if (cmd == CMD_READ) begin
            sb_q.push_back('{1'b1, model_word});
        end else if (cmd == CMD_WRITE) begin
            sb_q.push_back('{1'b0, 32'h0});
            model_word = wd;
        end
    endtask

    task automatic do_txn(input logic [1:0] cmd, input logic [31:0] wd);
        int  cyc;
        int  pulses;
        bit  seen;
        @(negedge pclk);
        issue(cmd, wd);
        if (cmd_is_xfer(cmd)) begin
            seen = 0;
            cyc  = -1;
            for (int i = 1; i <= 10 && !seen; i++) begin
                @(negedge pclk);
                if (i == 1) chk("setup_phase", {30'd0, dut0.apb_if.psel, dut0.apb_if.penable}, 32'd2);
                if (ready_o) begin
                    seen = 1;
                    cyc  = i;
                end
            end
            add_i = CMD_IDLE;
            chk("ready_latency", cyc, 32'd2);
        end else begin
            pulses = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge pclk);
                if (ready_o || dut0.apb_if.psel) pulses++;
            end
            add_i = CMD_IDLE;
            chk("idle_cmd_no_xfer", pulses, 32'd0);
        end
        repeat (2) @(negedge pclk);
    endtask

    task automatic ws2_txn(input logic [1:0] cmd, input logic [31:0] wd,
                           output int acc_cycles, output int addr_bad, output int psel_drop);
        bit seen;
        acc_cycles = 0;
        addr_bad   = 0;
        psel_drop  = 0;
        seen       = 0;
        @(negedge pclk);
        add2   = cmd;
        wdata2 = wd;
        @(negedge pclk);
        for (int i = 0; i < 15 && !seen; i++) begin
            @(negedge pclk);
            if (!dut2.apb_if.psel) psel_drop++;
            if (dut2.apb_if.paddr != 32'h10) addr_bad++;
            if (dut2.apb_if.psel && dut2.apb_if.penable) acc_cycles++;
            if (ready2) seen = 1;
        end
        add2 = CMD_IDLE;
        if (!seen) acc_cycles = -1;
        repeat (3) @(negedge pclk);
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[9];

    int first_rdy, second_rdy, acc, abad, pdrop;

    initial begin
        vecs[0] = '{CMD_WRITE, 32'h1234_ABCD, 32'h0000_0000};
        vecs[1] = '{CMD_READ,  32'h0,         32'h1234_ABCD};
        vecs[2] = '{CMD_IDLE,  32'h0,         32'h1234_ABCD};
        vecs[3] = '{CMD_READ,  32'h0,         32'h1234_ABCD};
        vecs[4] = '{CMD_WRITE, 32'hCAFE_F00D, 32'h1234_ABCD};
        vecs[5] = '{2'b10,     32'h0BAD_0BAD, 32'h1234_ABCD};
        vecs[6] = '{CMD_READ,  32'h0,         32'hCAFE_F00D};
        vecs[7] = '{CMD_WRITE, 32'h0000_0000, 32'hCAFE_F00D};
        vecs[8] = '{CMD_READ,  32'h0,         32'h0000_0000};

        model_word = 32'h0;
        last_rd    = 32'h0;
        add_i      = CMD_IDLE;
        add2       = CMD_IDLE;
        wdata      = 32'h0;
        wdata2     = 32'h0;
        preset_n   = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        preset_n = 1'b0;
        #1;
        chk("reset_ready", {31'd0, ready_o}, 32'd0);
        chk("reset_rdata", rdata_o, 32'd0);
        chk("reset_psel", {31'd0, dut0.apb_if.psel}, 32'd0);

        for (int v = 0; v < 9; v++) begin
            do_txn(vecs[v].cmd, vecs[v].wdata);
            chk($sformatf("vec%0d_rdata", v), rdata_o, vecs[v].exp_rdata);
        end

        // back-to-back reads with the command held
        @(negedge pclk);
        issue(CMD_READ, 32'h0);
        sb_q.push_back('{1'b1, model_word});
        first_rdy  = -1;
        second_rdy = -1;
        for (int i = 1; i <= 12 && second_rdy < 0; i++) begin
            @(negedge pclk);
            if (ready_o) begin
                if (first_rdy < 0) first_rdy = i;
                else second_rdy = i;
            end
        end
        add_i = CMD_IDLE;
        chk("b2b_first_ready", first_rdy, 32'd2);
        chk("b2b_second_ready", second_rdy, 32'd4);
        repeat (3) @(negedge pclk);

        // command and data change during SETUP must not affect the transfer
        @(negedge pclk);
        issue(CMD_WRITE, 32'h5555_AAAA);
        @(negedge pclk);
        add_i = CMD_IDLE;
        wdata = 32'hFFFF_FFFF;
        first_rdy = -1;
        for (int i = 2; i <= 10 && first_rdy < 0; i++) begin
            @(negedge pclk);
            if (ready_o) begin
                first_rdy = i;
                chk("midchg_pwdata", dut0.apb_if.pwdata, 32'h5555_AAAA);
            end
        end
        chk("midchg_ready_latency", first_rdy, 32'd2);
        repeat (2) @(negedge pclk);
        do_txn(CMD_READ, 32'h0);
        chk("midchg_readback", rdata_o, 32'h5555_AAAA);

        // WAIT_STATES=2 instance: write then read
        ws2_txn(CMD_WRITE, 32'h0F0F_1234, acc, abad, pdrop);
        chk("ws2_wr_access_cycles", acc, 32'd3);
        chk("ws2_wr_paddr_stable", abad, 32'd0);
        chk("ws2_wr_psel_stable", pdrop, 32'd0);
        chk("ws2_wr_rdata_unchanged", rdata2, 32'd0);
        ws2_txn(CMD_READ, 32'h0, acc, abad, pdrop);
        chk("ws2_rd_access_cycles", acc, 32'd3);
        chk("ws2_rd_paddr_stable", abad, 32'd0);
        chk("ws2_rd_psel_stable", pdrop, 32'd0);
        chk("ws2_rd_rdata", rdata2, 32'h0F0F_1234);

        // reset asserted in ACCESS of a write
        @(negedge pclk);
        add_i = CMD_WRITE;
        wdata = 32'hDEAD_BEEF;
        @(posedge pclk);
        #1;
        @(posedge pclk);
        #1;
        chk("rst_mid_in_access", {31'd0, dut0.apb_if.penable}, 32'd1);
        preset_n = 1'b1;
        #1;
        chk("rst_mid_psel", {31'd0, dut0.apb_if.psel}, 32'd0);
        chk("rst_mid_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_mid_rdata", rdata_o, 32'd0);
        add_i = CMD_IDLE;
        @(negedge pclk);
        preset_n   = 1'b0;
        model_word = 32'h0;
        last_rd    = 32'h0;
        do_txn(CMD_READ, 32'h0);
        chk("rst_mid_readback", rdata_o, 32'd0);

        chk("sb_queue_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
